// File: rtl/ram_bist.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bist
//  Description : Built-in self-test controller for a RAM with one write port
//                and two read ports (A, B). Each run writes a pattern over
//                0..END_ADDR, then reads it back on both ports at once: A
//                ascending, B descending. There are two passes: the address
//                value, then its complement. The first mismatch is captured
//                and ends the run early.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   asynchronous, active-low reset
//    start      in   begin a run (accepted in IDLE or DONE only)
//    busy       out  run in progress
//    done       out  run finished; held until next start or reset
//    fail       out  mismatch detected (valid with done)
//    err_port   out  port of first mismatch (0 = A, 1 = B)
//    err_addr   out  address of first mismatch
//    err_exp    out  expected word at first mismatch
//    err_data   out  word actually read at first mismatch
//    wr         out  RAM write enable
//    wr_addr    out  RAM write address
//    d_in       out  RAM write data
//    rd_addr_a  out  RAM read address, port A
//    rd_addr_b  out  RAM read address, port B
//    d_out_a    in   RAM read data, port A
//    d_out_b    in   RAM read data, port B
// ============================================================================
module ram_bist #(
    parameter int                ADDR_W   = 27,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] END_ADDR = 27'h7FFFFFF,
    parameter int                RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              err_port,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_data,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] d_out_a,
    input  logic [DATA_W-1:0] d_out_b
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Last drain-cycle index; unused when RD_LAT is 0 (DRAIN is skipped).
    localparam logic [ADDR_W-1:0] c_DRN_LAST = ADDR_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    logic [2:0]        r_state;
    logic              r_pass;      // 0: pattern = address, 1: complement
    logic [ADDR_W-1:0] r_idx;       // write/read index, reused as drain counter
    logic              r_fail;
    logic              r_err_port;
    logic [ADDR_W-1:0] r_err_addr;
    logic [DATA_W-1:0] r_err_exp;
    logic [DATA_W-1:0] r_err_data;

    logic              w_start_acc;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_addr_b;
    logic [DATA_W-1:0] w_base_idx;
    logic [DATA_W-1:0] w_base_b;
    logic [DATA_W-1:0] w_pat_idx;
    logic [DATA_W-1:0] w_pat_b;

    logic              w_cmp_vld;
    logic [ADDR_W-1:0] w_cmp_addr_a;
    logic [ADDR_W-1:0] w_cmp_addr_b;
    logic [DATA_W-1:0] w_cmp_exp_a;
    logic [DATA_W-1:0] w_cmp_exp_b;
    logic              w_err_a;
    logic              w_err_b;
    logic              w_err_new;
    logic              w_pass_next;

    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd_issue  = (r_state == S_READ);
    assign w_addr_b    = END_ADDR - r_idx;

    // ------------------------------------------------------------------
    // Pattern source: the low DATA_W bits of the address, zero-extended
    // when the data word is wider than the address.
    // ------------------------------------------------------------------
    if (DATA_W <= ADDR_W) begin : g_pat_trunc
        assign w_base_idx = r_idx[DATA_W-1:0];
        assign w_base_b   = w_addr_b[DATA_W-1:0];
    end else begin : g_pat_pad
        assign w_base_idx = {{(DATA_W-ADDR_W){1'b0}}, r_idx};
        assign w_base_b   = {{(DATA_W-ADDR_W){1'b0}}, w_addr_b};
    end

    assign w_pat_idx = r_pass ? ~w_base_idx : w_base_idx;
    assign w_pat_b   = r_pass ? ~w_base_b   : w_base_b;

    // ------------------------------------------------------------------
    // Compare alignment: the expected word and address of each read are
    // delayed to line up with the RAM's read latency.
    // ------------------------------------------------------------------
    if (RD_LAT == 0) begin : g_lat_zero
        assign w_cmp_vld    = w_rd_issue;
        assign w_cmp_addr_a = r_idx;
        assign w_cmp_addr_b = w_addr_b;
        assign w_cmp_exp_a  = w_pat_idx;
        assign w_cmp_exp_b  = w_pat_b;
    end else begin : g_lat_pipe
        logic              r_vld_q    [RD_LAT];
        logic [ADDR_W-1:0] r_addr_a_q [RD_LAT];
        logic [ADDR_W-1:0] r_addr_b_q [RD_LAT];
        logic [DATA_W-1:0] r_exp_a_q  [RD_LAT];
        logic [DATA_W-1:0] r_exp_b_q  [RD_LAT];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    r_vld_q[s]    <= 1'b0;
                    r_addr_a_q[s] <= '0;
                    r_addr_b_q[s] <= '0;
                    r_exp_a_q[s]  <= '0;
                    r_exp_b_q[s]  <= '0;
                end
            end else begin
                r_vld_q[0]    <= w_rd_issue;
                r_addr_a_q[0] <= r_idx;
                r_addr_b_q[0] <= w_addr_b;
                r_exp_a_q[0]  <= w_pat_idx;
                r_exp_b_q[0]  <= w_pat_b;
                for (int s = 1; s < RD_LAT; s++) begin
                    r_vld_q[s]    <= r_vld_q[s-1];
                    r_addr_a_q[s] <= r_addr_a_q[s-1];
                    r_addr_b_q[s] <= r_addr_b_q[s-1];
                    r_exp_a_q[s]  <= r_exp_a_q[s-1];
                    r_exp_b_q[s]  <= r_exp_b_q[s-1];
                end
            end
        end

        assign w_cmp_vld    = r_vld_q[RD_LAT-1];
        assign w_cmp_addr_a = r_addr_a_q[RD_LAT-1];
        assign w_cmp_addr_b = r_addr_b_q[RD_LAT-1];
        assign w_cmp_exp_a  = r_exp_a_q[RD_LAT-1];
        assign w_cmp_exp_b  = r_exp_b_q[RD_LAT-1];
    end

    assign w_err_a   = w_cmp_vld && (d_out_a != w_cmp_exp_a);
    assign w_err_b   = w_cmp_vld && (d_out_b != w_cmp_exp_b);
    // Only the first mismatch of a run is reported.
    assign w_err_new = !r_fail && (w_err_a || w_err_b);
    // A mismatch found in the same cycle as the pass decision must veto
    // the second pass, so the live compare result is included here.
    assign w_pass_next = !r_pass && !r_fail && !w_err_new;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_WRITE;
                        r_pass  <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                S_WRITE: begin
                    if (r_idx == END_ADDR) begin
                        r_state <= S_READ;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                S_READ: begin
                    if (w_err_new || (r_idx == END_ADDR)) begin
                        r_idx <= '0;
                        if (RD_LAT == 0) begin
                            // No reads in flight: decide the next pass now.
                            if (w_pass_next) begin
                                r_state <= S_WRITE;
                                r_pass  <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_idx == c_DRN_LAST) begin
                        r_idx <= '0;
                        if (w_pass_next) begin
                            r_state <= S_WRITE;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-error capture; port A wins a same-cycle tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fail     <= 1'b0;
            r_err_port <= 1'b0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_data <= '0;
        end else if (w_start_acc) begin
            r_fail     <= 1'b0;
            r_err_port <= 1'b0;
            r_err_addr <= '0;
            r_err_exp  <= '0;
            r_err_data <= '0;
        end else if (w_err_new) begin
            r_fail <= 1'b1;
            if (w_err_a) begin
                r_err_port <= 1'b0;
                r_err_addr <= w_cmp_addr_a;
                r_err_exp  <= w_cmp_exp_a;
                r_err_data <= d_out_a;
            end else begin
                r_err_port <= 1'b1;
                r_err_addr <= w_cmp_addr_b;
                r_err_exp  <= w_cmp_exp_b;
                r_err_data <= d_out_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decode straight from the state register, so an asynchronous
    // reset clears the RAM interface immediately. Addresses and data are
    // held at zero outside the states that use them.
    // ------------------------------------------------------------------
    assign busy      = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign fail      = r_fail;
    assign err_port  = r_err_port;
    assign err_addr  = r_err_addr;
    assign err_exp   = r_err_exp;
    assign err_data  = r_err_data;
    assign wr        = (r_state == S_WRITE);
    assign wr_addr   = (r_state == S_WRITE) ? r_idx     : '0;
    assign d_in      = (r_state == S_WRITE) ? w_pat_idx : '0;
    assign rd_addr_a = w_rd_issue ? r_idx    : '0;
    assign rd_addr_b = w_rd_issue ? w_addr_b : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_bist
//  Description : Self-checking bench for ram_bist. One instance tests 16
//                words with a registered-read RAM model; a second instance
//                tests a single word with a combinational-read RAM model.
//                Both models carry a programmable stuck-at read fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bist;

    localparam int AW = 27;
    localparam int DW = 16;
    localparam logic [AW-1:0] END1 = 27'd15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- 16-word instance, RD_LAT = 1 ----------------
    logic          start1 = 1'b0;
    logic          busy1, done1, fail1, errp1, wr1;
    logic [AW-1:0] erra1, wra1, ra1, rb1;
    logic [DW-1:0] erre1, errd1, din1;
    logic [DW-1:0] qa1, qb1;

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .END_ADDR(END1), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .busy(busy1), .done(done1),
        .fail(fail1), .err_port(errp1), .err_addr(erra1), .err_exp(erre1),
        .err_data(errd1), .wr(wr1), .wr_addr(wra1), .d_in(din1),
        .rd_addr_a(ra1), .rd_addr_b(rb1), .d_out_a(qa1), .d_out_b(qb1)
    );

    logic [DW-1:0] mem1 [16];
    logic          f_en   = 1'b0;
    logic [3:0]    f_addr = 4'd0;
    logic [DW-1:0] f_mask = '0;
    logic          f_set  = 1'b0;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (f_en && (a == AW'(f_addr))) r = f_set ? (d | f_mask) : (d & ~f_mask);
        return r;
    endfunction

    always @(posedge clk) begin
        if (wr1) mem1[wra1[3:0]] <= din1;
        qa1 <= faulty(ra1, mem1[ra1[3:0]]);
        qb1 <= faulty(rb1, mem1[rb1[3:0]]);
    end

    // ---------------- 1-word instance, RD_LAT = 0 ----------------
    logic          start0 = 1'b0;
    logic          busy0, done0, fail0, errp0, wr0;
    logic [AW-1:0] erra0, wra0, ra0, rb0;
    logic [DW-1:0] erre0, errd0, din0;
    logic [DW-1:0] qa0, qb0;
    logic [DW-1:0] mem0;
    logic          f0_en = 1'b0;   // bit 0 stuck-at-0 on both read ports

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .END_ADDR(27'd0), .RD_LAT(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .start(start0), .busy(busy0), .done(done0),
        .fail(fail0), .err_port(errp0), .err_addr(erra0), .err_exp(erre0),
        .err_data(errd0), .wr(wr0), .wr_addr(wra0), .d_in(din0),
        .rd_addr_a(ra0), .rd_addr_b(rb0), .d_out_a(qa0), .d_out_b(qb0)
    );

    always @(posedge clk) if (wr0) mem0 <= din0;
    assign qa0 = f0_en ? (mem0 & ~16'h0001) : mem0;
    assign qb0 = f0_en ? (mem0 & ~16'h0001) : mem0;

    // ---------------- scoreboard queues ----------------
    logic [AW+DW-1:0] q_exp_wr [$];   // expected {addr, data} writes
    logic [AW+DW-1:0] q_wr     [$];   // observed writes
    logic [2*AW-1:0]  q_exp_rd [$];   // expected {addr_a, addr_b} reads
    logic [2*AW-1:0]  q_rd     [$];   // observed reads

    // Start pulse: begins and ends at a falling edge; on return the first
    // busy cycle is on the bus.
    task automatic pulse1();
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    endtask
    task automatic pulse0();
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    endtask

    // Monitors instance 1 until done; records writes and read address pairs
    // (a read cycle drives A = j, B = END-j, so the pair sums to END).
    task automatic collect1(input int limit, output int nbusy, output bit tmo);
        nbusy = 0; tmo = 1'b1;
        for (int c = 0; c < limit; c++) begin
            if (done1) begin tmo = 1'b0; break; end
            if (busy1) nbusy++;
            if (wr1) q_wr.push_back({wra1, din1});
            if (busy1 && !wr1 && ((ra1 + rb1) == END1)) q_rd.push_back({ra1, rb1});
            @(negedge clk);
        end
    endtask

    task automatic collect0(input int limit, output int nbusy, output bit tmo);
        nbusy = 0; tmo = 1'b1;
        for (int c = 0; c < limit; c++) begin
            if (done0) begin tmo = 1'b0; break; end
            if (busy0) nbusy++;
            if (wr0) q_wr.push_back({wra0, din0});
            @(negedge clk);
        end
    endtask

    task automatic clear_q();
        q_exp_wr.delete(); q_wr.delete(); q_exp_rd.delete(); q_rd.delete();
    endtask

    // ================= tests =================
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if ({busy1, done1, fail1, errp1, wr1} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {busy1, done1, fail1, errp1, wr1}); end
        n_vec++; if ({wra1, ra1, rb1} !== '0) begin n_err++; $display("FAIL reset_addr: got wr %0h a %0h b %0h want 0", wra1, ra1, rb1); end
        n_vec++; if ({erra1, erre1, errd1, din1} !== '0) begin n_err++; $display("FAIL reset_err: got addr %0h exp %h data %h din %h want 0", erra1, erre1, errd1, din1); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({busy1, done1} !== 2'b00) begin n_err++; $display("FAIL reset_idle: got busy/done %b want 00", {busy1, done1}); end
    endtask

    task automatic test_clean();
        int nb; bit tmo;
        logic [DW-1:0] d;
        logic [AW+DW-1:0] e, o;
        logic [2*AW-1:0] er, orr;
        clear_q();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                d = DW'(i); if (k == 1) d = ~d;
                q_exp_wr.push_back({AW'(i), d});
                q_exp_rd.push_back({AW'(i), AW'(15 - i)});
            end
        end
        pulse1();
        collect1(300, nb, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL clean_timeout: got no done within 300 cycles want done"); end
        n_vec++; if (nb !== 66) begin n_err++; $display("FAIL clean_busy: got %0d cycles want 66", nb); end
        n_vec++; if ({done1, fail1} !== 2'b10) begin n_err++; $display("FAIL clean_result: got done/fail %b want 10", {done1, fail1}); end
        n_vec++; if (q_wr.size() !== 32) begin n_err++; $display("FAIL clean_wr_count: got %0d want 32", q_wr.size()); end
        while (q_exp_wr.size() > 0 && q_wr.size() > 0) begin
            e = q_exp_wr.pop_front(); o = q_wr.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL clean_wr: got addr %0h data %h want addr %0h data %h", o[AW+DW-1:DW], o[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]); end
        end
        n_vec++; if (q_rd.size() !== 32) begin n_err++; $display("FAIL clean_rd_count: got %0d want 32", q_rd.size()); end
        while (q_exp_rd.size() > 0 && q_rd.size() > 0) begin
            er = q_exp_rd.pop_front(); orr = q_rd.pop_front();
            n_vec++; if (orr !== er) begin n_err++; $display("FAIL clean_rd: got a %0h b %0h want a %0h b %0h", orr[2*AW-1:AW], orr[AW-1:0], er[2*AW-1:AW], er[AW-1:0]); end
        end
    endtask

    // Address 5 bit 3 stuck-at-1: port A (index 5) catches it in pass 0.
    // 16 writes + reads 0..6 (read 6 was issued while read 5 was compared)
    // + 1 drain cycle = 24 busy cycles.
    task automatic test_fault_port_a();
        int nb; bit tmo;
        logic [AW+DW-1:0] e, o;
        clear_q();
        f_en = 1'b1; f_addr = 4'd5; f_mask = 16'h0008; f_set = 1'b1;
        for (int i = 0; i < 16; i++) q_exp_wr.push_back({AW'(i), DW'(i)});
        pulse1();
        collect1(300, nb, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL fa_timeout: got no done within 300 cycles want done"); end
        n_vec++; if ({done1, fail1, errp1} !== 3'b110) begin n_err++; $display("FAIL fa_flags: got done/fail/port %b want 110", {done1, fail1, errp1}); end
        n_vec++; if (erra1 !== 27'd5) begin n_err++; $display("FAIL fa_addr: got %0h want 5", erra1); end
        n_vec++; if (erre1 !== 16'h0005) begin n_err++; $display("FAIL fa_exp: got %h want 0005", erre1); end
        n_vec++; if (errd1 !== 16'h000D) begin n_err++; $display("FAIL fa_data: got %h want 000d", errd1); end
        n_vec++; if (nb !== 24) begin n_err++; $display("FAIL fa_busy: got %0d cycles want 24", nb); end
        n_vec++; if (q_rd.size() !== 7) begin n_err++; $display("FAIL fa_rd_count: got %0d want 7", q_rd.size()); end
        n_vec++; if (q_wr.size() !== 16) begin n_err++; $display("FAIL fa_wr_count: got %0d want 16 (no pass-1 writes)", q_wr.size()); end
        while (q_exp_wr.size() > 0 && q_wr.size() > 0) begin
            e = q_exp_wr.pop_front(); o = q_wr.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL fa_wr: got addr %0h data %h want addr %0h data %h", o[AW+DW-1:DW], o[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]); end
        end
        f_en = 1'b0;
    endtask

    // Address 14 bit 0 stuck-at-0: invisible in pass 0, port B (index 1)
    // catches it in pass 1. 33 + 16 writes + 3 reads + 1 drain = 53.
    task automatic test_fault_port_b();
        int nb; bit tmo;
        clear_q();
        f_en = 1'b1; f_addr = 4'd14; f_mask = 16'h0001; f_set = 1'b0;
        pulse1();
        collect1(300, nb, tmo);
        n_vec++; if (tmo) begin n_err++; $display("FAIL fb_timeout: got no done within 300 cycles want done"); end
        n_vec++; if ({done1, fail1, errp1} !== 3'b111) begin n_err++; $display("FAIL fb_flags: got done/fail/port %b want 111", {done1, fail1, errp1}); end
        n_vec++; if (erra1 !== 27'd14) begin n_err++; $display("FAIL fb_addr: got %0h want e", erra1); end
        n_vec++; if (erre1 !== 16'hFFF1) begin n_err++; $display("FAIL fb_exp: got %h want fff1", erre1); end
        n_vec++; if (errd1 !== 16'hFFF0) begin n_err++; $display("FAIL fb_data: got %h want fff0", errd1); end
        n_vec++; if (nb !== 53) begin n_err++; $display("FAIL fb_busy: got %0d cycles want 53", nb); end
        n_vec++; if (q_wr.size() !== 32) begin n_err++; $display("FAIL fb_wr_count: got %0d want 32", q_wr.size()); end
        f_en = 1'b0;
    endtask

    // Restart from a failed DONE clears the result at once; start pulses
    // during WRITE and READ leave the run length unchanged.
    task automatic test_restart_ignore();
        int nb; bit tmo;
        clear_q();
        pulse1();
        n_vec++; if ({busy1, done1, fail1} !== 3'b100) begin n_err++; $display("FAIL rs_clear: got busy/done/fail %b want 100", {busy1, done1, fail1}); end
        n_vec++; if ({errp1, erra1, erre1, errd1} !== '0) begin n_err++; $display("FAIL rs_err_clear: got port %b addr %0h exp %h data %h want 0", errp1, erra1, erre1, errd1); end
        fork
            collect1(300, nb, tmo);
            begin
                repeat (3) @(negedge clk);
                start1 = 1'b1; @(negedge clk); start1 = 1'b0;
                repeat (20) @(negedge clk);
                start1 = 1'b1; @(negedge clk); start1 = 1'b0;
            end
        join
        n_vec++; if (tmo) begin n_err++; $display("FAIL rs_timeout: got no done within 300 cycles want done"); end
        n_vec++; if (nb !== 66) begin n_err++; $display("FAIL rs_busy: got %0d cycles want 66", nb); end
        n_vec++; if ({done1, fail1} !== 2'b10) begin n_err++; $display("FAIL rs_result: got done/fail %b want 10", {done1, fail1}); end
        n_vec++; if (q_wr.size() !== 32) begin n_err++; $display("FAIL rs_wr_count: got %0d want 32", q_wr.size()); end
    endtask

    task automatic test_reset_abort();
        int nb; bit tmo;
        clear_q();
        pulse1();
        repeat (20) @(negedge clk);   // pass-0 READ, index 4
        n_vec++; if ({busy1, wr1, ra1, rb1} !== {1'b1, 1'b0, 27'd4, 27'd11}) begin n_err++; $display("FAIL ab_pre: got busy %b wr %b a %0h b %0h want 1 0 4 b", busy1, wr1, ra1, rb1); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({wr1, busy1, done1, fail1} !== 4'b0) begin n_err++; $display("FAIL ab_flags: got wr/busy/done/fail %b want 0000", {wr1, busy1, done1, fail1}); end
        n_vec++; if ({wra1, ra1, rb1, din1} !== '0) begin n_err++; $display("FAIL ab_addr: got wr %0h a %0h b %0h din %h want 0", wra1, ra1, rb1, din1); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if ({busy1, done1} !== 2'b00) begin n_err++; $display("FAIL ab_idle: got busy/done %b want 00", {busy1, done1}); end
        clear_q();
        pulse1();
        collect1(300, nb, tmo);
        n_vec++; if (tmo || nb !== 66) begin n_err++; $display("FAIL ab_rerun_busy: got %0d cycles timeout %b want 66", nb, tmo); end
        n_vec++; if ({done1, fail1} !== 2'b10) begin n_err++; $display("FAIL ab_rerun_result: got done/fail %b want 10", {done1, fail1}); end
    endtask

    task automatic test_min_depth();
        int nb; bit tmo;
        logic [AW+DW-1:0] e, o;
        clear_q();
        q_exp_wr.push_back({27'd0, 16'h0000});
        q_exp_wr.push_back({27'd0, 16'hFFFF});
        pulse0();
        collect0(50, nb, tmo);
        n_vec++; if (tmo || nb !== 4) begin n_err++; $display("FAIL min_busy: got %0d cycles timeout %b want 4", nb, tmo); end
        n_vec++; if ({done0, fail0} !== 2'b10) begin n_err++; $display("FAIL min_result: got done/fail %b want 10", {done0, fail0}); end
        n_vec++; if (q_wr.size() !== 2) begin n_err++; $display("FAIL min_wr_count: got %0d want 2", q_wr.size()); end
        while (q_exp_wr.size() > 0 && q_wr.size() > 0) begin
            e = q_exp_wr.pop_front(); o = q_wr.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL min_wr: got addr %0h data %h want addr %0h data %h", o[AW+DW-1:DW], o[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]); end
        end
        // Same-cycle compare path: bit 0 stuck-at-0 shows only in pass 1,
        // on both ports at once, so port A is reported.
        clear_q();
        f0_en = 1'b1;
        pulse0();
        collect0(50, nb, tmo);
        n_vec++; if (tmo || nb !== 4) begin n_err++; $display("FAIL min_f_busy: got %0d cycles timeout %b want 4", nb, tmo); end
        n_vec++; if ({done0, fail0, errp0} !== 3'b110) begin n_err++; $display("FAIL min_f_flags: got done/fail/port %b want 110", {done0, fail0, errp0}); end
        n_vec++; if ({erra0, erre0, errd0} !== {27'd0, 16'hFFFF, 16'hFFFE}) begin n_err++; $display("FAIL min_f_err: got addr %0h exp %h data %h want 0 ffff fffe", erra0, erre0, errd0); end
        f0_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_fault_port_a();
        test_fault_port_b();
        test_restart_ignore();
        test_reset_abort();
        test_min_depth();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ram_bist.md
# ram_bist

Built-in self-test controller for the dual-read-port RAM (one write port, read ports A and B). It drives the RAM's write and read interface as the initiator and checks both read data buses. Each run makes two passes: write a pattern, then read it back. The block reports pass/fail and captures the first mismatch. It sits beside the RAM and owns the RAM's port signals while busy; bring-up logic starts it and samples the result.

## Interface

Parameters:
- ADDR_W, 27, RAM address width
- DATA_W, 16, RAM data width
- END_ADDR, 27'h7FFFFFF, last address tested; range is 0..END_ADDR, N = END_ADDR+1
- RD_LAT, 1, RAM read latency in cycles, from rd_addr to d_out (0 or 1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled in IDLE or DONE only
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- fail  out  1  mismatch detected; valid when done=1
- err_port  out  1  port of first mismatch (0=A, 1=B)
- err_addr  out  ADDR_W  address of first mismatch
- err_exp  out  DATA_W  expected word at first mismatch
- err_data  out  DATA_W  word actually read at first mismatch
- wr  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- d_in  out  DATA_W  RAM write data
- rd_addr_a  out  ADDR_W  RAM read address, port A
- rd_addr_b  out  ADDR_W  RAM read address, port B
- d_out_a  in  DATA_W  RAM read data, port A
- d_out_b  in  DATA_W  RAM read data, port B

## Operation

- Reset values: all outputs are 0. State is IDLE.
- Reset takes effect immediately, mid-run included. It forces wr=0 and aborts the run with no done indication.
- States: IDLE, WRITE, READ, DRAIN, DONE. A pass counter k takes the value 0 or 1.
- Pattern: P(a,k) = a[DATA_W-1:0] for k=0, and ~a[DATA_W-1:0] for k=1.
- IDLE or DONE with start=1 → WRITE, k=0. On this transition, clear done, fail and err_*.
- start is ignored in WRITE, READ and DRAIN.
- WRITE: wr=1, wr_addr=i, d_in=P(i,k) for i = 0..END_ADDR, one address per cycle. After i=END_ADDR → READ.
- READ: for cycle index j = 0..END_ADDR:
  - port A reads ascending: rd_addr_a=j
  - port B reads descending: rd_addr_b=END_ADDR−j
  - wr=0
  - every address is checked on both ports.
- Compare pipeline:
  - Expected data and address for each port are delayed RD_LAT cycles with a valid bit.
  - A mismatch on a valid stage is an error.
  - The first error is latched: fail=1, plus err_*.
  - If A and B both mismatch in the same cycle, port A wins.
  - Later errors are not captured.
- On the first error: stop issuing reads and go to DRAIN. Pass 1 is not run.
- After the last read (j=END_ADDR) → DRAIN.
- DRAIN lasts RD_LAT cycles (zero when RD_LAT=0). It exits to WRITE with k=1 if k=0 and no error; otherwise to DONE.
- DONE: busy=0, done=1. Outputs hold until start or reset.
- Address arithmetic is ADDR_W wide. END_ADDR=0 is legal (N=1).

## Timing

- start sampled high at edge T → busy=1 and the first write (addr 0) is presented from T+1.
- A write is committed at the edge that ends its cycle. The first read follows the last write with no idle cycle.
- A clean run keeps busy high for exactly 2·(2N+RD_LAT) cycles, then done=1 in the next cycle.
- Read data is compared RD_LAT cycles after its address is driven. With RD_LAT=0 it is compared in the same cycle.
- err_* and fail update at the edge after the mismatching compare cycle.
- After an error: done rises after the remaining drain cycles, with no further reads issued.

## Test plan

Bench uses a behavioural RAM model with a programmable fault; END_ADDR=15, RD_LAT=1 unless stated.

1. Clean RAM, single start pulse → busy high 66 cycles, then done=1, fail=0.
   - Pass 0 writes 0x0000..0x000F to addresses 0..15.
   - Pass 1 writes 0xFFFF..0xFFF0.
2. Address 5, bit 3 stuck-at-1 → during pass 0:
   - port A (read index 5) sees 0x000D, before port B (index 10).
   - Result: fail=1, err_port=0, err_addr=5, err_exp=0x0005, err_data=0x000D.
   - done follows after 1 drain cycle; no pass-1 writes occur.
3. Address 14, bit 0 stuck-at-0 → pass 0 clean. In pass 1:
   - port B reads address 14 at index 1.
   - Result: fail=1, err_port=1, err_addr=14, err_exp=0xFFF1, err_data=0xFFF0.
4. Reset driven low during pass-0 READ → immediately: wr=0, busy=0, done=0, all addresses 0. After release, a new start gives a clean 66-cycle run.
5. start pulsed during WRITE and READ → ignored; run length is unchanged. start after DONE clears done/fail and reruns; busy=1 on the next cycle.
6. RD_LAT=0, END_ADDR=0, clean → busy for 4 cycles, done=1, fail=0. Only address 0 is written (0x0000 then 0xFFFF) and read back on both ports.
